// File: rtl/gol_pkg.sv
// Shared types and rule constants for the Game-of-Life grid engine.
package gol_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [3:0] nbr_cnt_t;

    localparam nbr_cnt_t BIRTH_N   = 4'd3;
    localparam nbr_cnt_t SURVIVE_N = 4'd2;

endpackage

// File: rtl/gol_cell.sv
// Single Game-of-Life cell rule: counts the eight neighbour bits and
// applies the birth/survival rule to produce the cell's next state.
module gol_cell
    import gol_pkg::*;
(
    input  logic [7:0] nbr,
    input  logic       cur,
    output logic       nxt
);

    nbr_cnt_t cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + nbr_cnt_t'(nbr[i]);
        end
        nxt = (cnt == BIRTH_N) || (cur && (cnt == SURVIVE_N));
    end

endmodule

// File: rtl/gol_grid_engine.sv
// WIDTH x HEIGHT Game-of-Life array, one generation per clock with early stop.
// Define GOL_TORUS_EN for wrap-around edges; otherwise outside cells are dead.
module gol_grid_engine
    import gol_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 8,
    parameter int ROW_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ROW_W-1:0]  load_row,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              start,
    input  logic [GEN_W-1:0]  gens,
    output logic              busy,
    output logic              done,
    output logic              stable,
    output logic [GEN_W-1:0]  gen_count,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [WIDTH-1:0]  rd_data,
    output logic              alive_any
);

    typedef logic [HEIGHT-1:0][WIDTH-1:0] grid_t;

    state_t           state_q, state_d;
    grid_t            grid_q, grid_d, grid_nxt;
    logic [GEN_W-1:0] gens_q, gens_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d, gen_inc;
    logic             stable_q, stable_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Neighbour indices are resolved at elaboration; only the edge policy differs.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            localparam int RU = (r == 0) ? HEIGHT - 1 : r - 1;
            localparam int RD = (r == HEIGHT - 1) ? 0 : r + 1;
            localparam int CL = (c == 0) ? WIDTH - 1 : c - 1;
            localparam int CR = (c == WIDTH - 1) ? 0 : c + 1;
            logic [7:0] nbr;
`ifdef GOL_TORUS_EN
            assign nbr = {grid_q[RU][CL], grid_q[RU][c], grid_q[RU][CR],
                          grid_q[r][CL],                 grid_q[r][CR],
                          grid_q[RD][CL], grid_q[RD][c], grid_q[RD][CR]};
`else
            localparam bit VU = (r > 0);
            localparam bit VD = (r < HEIGHT - 1);
            localparam bit VL = (c > 0);
            localparam bit VR = (c < WIDTH - 1);
            assign nbr = {(VU && VL) ? grid_q[RU][CL] : 1'b0,
                          VU         ? grid_q[RU][c]  : 1'b0,
                          (VU && VR) ? grid_q[RU][CR] : 1'b0,
                          VL         ? grid_q[r][CL]  : 1'b0,
                          VR         ? grid_q[r][CR]  : 1'b0,
                          (VD && VL) ? grid_q[RD][CL] : 1'b0,
                          VD         ? grid_q[RD][c]  : 1'b0,
                          (VD && VR) ? grid_q[RD][CR] : 1'b0};
`endif
            gol_cell u_cell (
                .nbr (nbr),
                .cur (grid_q[r][c]),
                .nxt (grid_nxt[r][c])
            );
        end
    end

    assign gen_inc = gen_count_q + GEN_W'(1);

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        gens_d      = gens_q;
        gen_count_d = gen_count_q;
        stable_d    = stable_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    for (int r = 0; r < HEIGHT; r++) begin
                        if (load_row == ROW_W'(r)) begin
                            grid_d[r] = load_data;
                            stable_d  = 1'b0;
                        end
                    end
                end else if (start) begin
                    gen_count_d = '0;
                    stable_d    = 1'b0;
                    if (gens == '0) begin
                        done_d = 1'b1;
                    end else begin
                        gens_d  = gens;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                grid_d      = grid_nxt;
                gen_count_d = gen_inc;
                if (grid_nxt == grid_q) begin
                    stable_d = 1'b1;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                end else if (gen_inc == gens_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grid_q      <= '0;
            gens_q      <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            gens_q      <= gens_d;
            gen_count_q <= gen_count_d;
            stable_q    <= stable_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (rd_row == ROW_W'(r)) begin
                rd_data = grid_q[r];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stable    = stable_q;
    assign gen_count = gen_count_q;
    assign alive_any = |grid_q;

endmodule

// File: tb/tb_gol_grid_engine.sv
// Bench for gol_grid_engine: generation-level model compared every cycle,
// plus directed scenarios with hand-computed grids.
`timescale 1ns/100ps
module tb_gol_grid_engine;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int GW = 8;
    localparam int RW = 3;

    typedef logic [H-1:0][W-1:0] grid_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [RW-1:0] load_row = '0;
    logic [W-1:0]  load_data = '0;
    logic          start = 1'b0;
    logic [GW-1:0] gens = '0;
    logic          busy, done, stable, alive_any;
    logic [GW-1:0] gen_count;
    logic [RW-1:0] rd_row = '0;
    logic [W-1:0]  rd_data;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    gol_grid_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW), .ROW_W(RW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .start(start), .gens(gens), .busy(busy),
        .done(done), .stable(stable), .gen_count(gen_count), .rd_row(rd_row),
        .rd_data(rd_data), .alive_any(alive_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain neighbour counting over the whole board.
    function automatic grid_t next_gen(input grid_t g);
        grid_t res;
        int n, rr, cc;
        res = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef GOL_TORUS_EN
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            if (g[rr][cc]) n++;
`else
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W && g[rr][cc]) n++;
`endif
                        end
                    end
                end
                res[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        return res;
    endfunction

    grid_t         m_grid, m_nxt;
    logic          m_run, m_done, m_stable;
    logic [GW-1:0] m_cnt, m_gens;

    always_comb m_nxt = next_gen(m_grid);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grid <= '0; m_run <= 1'b0; m_done <= 1'b0;
            m_stable <= 1'b0; m_cnt <= '0; m_gens <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_run) begin
                if (load_en) begin
                    if (int'(load_row) < H) begin
                        m_grid[load_row] <= load_data;
                        m_stable <= 1'b0;
                    end
                end else if (start) begin
                    m_cnt <= '0;
                    m_stable <= 1'b0;
                    if (gens == '0) m_done <= 1'b1;
                    else begin
                        m_gens <= gens;
                        m_run <= 1'b1;
                    end
                end
            end else begin
                m_grid <= m_nxt;
                m_cnt <= m_cnt + 8'd1;
                if (m_nxt == m_grid) begin
                    m_stable <= 1'b1; m_run <= 1'b0; m_done <= 1'b1;
                end else if (m_cnt + 8'd1 == m_gens) begin
                    m_run <= 1'b0; m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", 64'(busy), 64'(m_run));
            chk("done", 64'(done), 64'(m_done));
            chk("stable", 64'(stable), 64'(m_stable));
            chk("gen_count", 64'(gen_count), 64'(m_cnt));
            chk("alive_any", 64'(alive_any), 64'(|m_grid));
            for (int r = 0; r < H; r++) begin
                rd_row = RW'(r);
                #0.5;
                chk("rd_data", 64'(rd_data), 64'(m_grid[r]));
            end
        end
    end

    task automatic put_row(input int r, input logic [W-1:0] d);
        @(negedge clk);
        load_en = 1'b1; load_row = RW'(r); load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_grid();
        for (int r = 0; r < H; r++) put_row(r, '0);
    endtask

    task automatic run_gens(input logic [GW-1:0] g, input int budget);
        @(negedge clk);
        start = 1'b1; gens = g;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #11;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_count", 64'(gen_count), 64'd0);
        chk("rst_alive", 64'(alive_any), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Blinker flips to vertical, then back
        put_row(2, 8'h0E);
        run_gens(8'd1, 5);
        chk("blink1_grid", 64'(m_grid), 64'h0000_0000_0404_0400);
        chk("blink1_count", 64'(gen_count), 64'd1);
        chk("blink1_stable", 64'(stable), 64'd0);
        run_gens(8'd1, 5);
        chk("blink2_grid", 64'(m_grid), 64'h0000_0000_000E_0000);

        // Block still life stops after one step
        clear_grid();
        put_row(3, 8'h18);
        put_row(4, 8'h18);
        run_gens(8'd10, 20);
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_count", 64'(gen_count), 64'd1);
        chk("block_grid", 64'(m_grid), 64'h0000_0018_1800_0000);

        // Corner cells
        clear_grid();
        put_row(0, 8'h81);
        put_row(7, 8'h01);
        run_gens(8'd1, 5);
`ifdef GOL_TORUS_EN
        chk("corner_grid", 64'(m_grid), 64'h8100_0000_0000_0081);
        chk("corner_alive", 64'(alive_any), 64'd1);
`else
        chk("corner_grid", 64'(m_grid), 64'h0);
        chk("corner_alive", 64'(alive_any), 64'd0);
`endif

        // Glider
        clear_grid();
        put_row(0, 8'h02);
        put_row(1, 8'h04);
        put_row(2, 8'h07);
        run_gens(8'd32, 40);
`ifdef GOL_TORUS_EN
        chk("glider_grid", 64'(m_grid), 64'h0000_0000_0007_0402);
        chk("glider_count", 64'(gen_count), 64'd32);
        chk("glider_stable", 64'(stable), 64'd0);
`endif

        // gens = 0
        run_gens(8'd0, 3);
        chk("g0_count", 64'(gen_count), 64'd0);
        chk("g0_busy", 64'(busy), 64'd0);
        chk("g0_stable", 64'(stable), 64'd0);

        // Commands during RUN are ignored
        clear_grid();
        put_row(2, 8'h0E);
        @(negedge clk);
        start = 1'b1; gens = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; start = 1'b1; gens = 8'd1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_count", 64'(gen_count), 64'd4);
        chk("ign_grid", 64'(m_grid), 64'h0000_0000_000E_0000);

        // Simultaneous load and start: load wins
        @(negedge clk);
        load_en = 1'b1; load_row = 3'd0; load_data = 8'h3C; start = 1'b1; gens = 8'd5;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        chk("both_busy", 64'(busy), 64'd0);
        chk("both_row0", 64'(m_grid[0]), 64'h3C);
        @(negedge clk);
        chk("both_busy2", 64'(busy), 64'd0);

        // Reset mid-run
        clear_grid();
        put_row(2, 8'h0E);
        @(negedge clk);
        start = 1'b1; gens = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rrst_alive", 64'(alive_any), 64'd0);
        chk("rrst_busy", 64'(busy), 64'd0);
        chk("rrst_count", 64'(gen_count), 64'd0);
        chk("rrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rrst_nodone", 64'(done), 64'd0);
        put_row(3, 8'h18);
        put_row(4, 8'h18);
        run_gens(8'd10, 20);
        chk("rrst_stable", 64'(stable), 64'd1);
        chk("rrst_gcount", 64'(gen_count), 64'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
